// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
// Direction and mode encodings match the up_dn / sat_mode port polarities.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Operands are carried at the widest legal counter width plus one bit.
  localparam int CLAMP_W = 33;

  function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] val,
                                                    input logic [CLAMP_W-1:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate limit handling,
// combinational terminal-count carry and registered wrap/overflow status.
module updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH:0]   MAX_VAL  = {1'b0, {WIDTH{1'b1}}},
  parameter logic [WIDTH:0]   INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             ovf
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   cnt_ext;
  logic             at_max;
  logic             at_zero;
  logic             limit_evt;

  assign cnt_ext = {1'b0, out_q};
  assign at_max  = (cnt_ext == MAX_VAL);
  assign at_zero = (cnt_ext == '0);

  // Carry for cascading: suppressed whenever this edge will not count.
  assign tc = reset & ~load & en & ((up_dn == DIR_UP) ? at_max : at_zero);

  always_comb begin
    out_d     = out_q;
    limit_evt = 1'b0;
    if (load) begin
      out_d = WIDTH'(clamp_load(CLAMP_W'(load_val), CLAMP_W'(MAX_VAL)));
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (at_max) begin
          limit_evt = 1'b1;
          out_d     = (sat_mode == MODE_SAT) ? out_q : '0;
        end else begin
          out_d = WIDTH'(cnt_ext + (WIDTH+1)'(1));
        end
      end else begin
        if (at_zero) begin
          limit_evt = 1'b1;
          out_d     = (sat_mode == MODE_SAT) ? out_q : WIDTH'(MAX_VAL);
        end else begin
          out_d = WIDTH'(cnt_ext - (WIDTH+1)'(1));
        end
      end
    end
  end

  assign wrap_d = limit_evt;
  // A limit event on the same edge as a clear leaves the flag set.
  assign ovf_d  = limit_evt | (ovf_q & ~clr_ovf);

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= WIDTH'(INIT_VAL);
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out        = out_q;
  assign wrap_pulse = wrap_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed scenarios, random stimulus
// against an arithmetic reference model, and a two-stage decimal cascade.
module tb_updown_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, en, up_dn, load, sat_mode, clr_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] out;
  logic         tc, wrap_pulse, ovf;

  updown_counter #(.WIDTH(W), .MAX_VAL(5'd9), .INIT_VAL(5'd0)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .out(out), .tc(tc), .wrap_pulse(wrap_pulse), .ovf(ovf)
  );

  logic         c_rst;
  logic         c_en;
  logic         c_zero;
  logic [W-1:0] c_zero_val;
  logic [W-1:0] c_lo_out, c_hi_out;
  logic         c_lo_tc, c_hi_tc, c_lo_wp, c_hi_wp, c_lo_ovf, c_hi_ovf;

  updown_counter #(.WIDTH(W), .MAX_VAL(5'd9), .INIT_VAL(5'd0)) u_lo (
    .clk(clk), .reset(c_rst), .en(c_en), .up_dn(1'b1), .load(c_zero),
    .load_val(c_zero_val), .sat_mode(c_zero), .clr_ovf(c_zero),
    .out(c_lo_out), .tc(c_lo_tc), .wrap_pulse(c_lo_wp), .ovf(c_lo_ovf)
  );

  updown_counter #(.WIDTH(W), .MAX_VAL(5'd9), .INIT_VAL(5'd0)) u_hi (
    .clk(clk), .reset(c_rst), .en(c_lo_tc), .up_dn(1'b1), .load(c_zero),
    .load_val(c_zero_val), .sat_mode(c_zero), .clr_ovf(c_zero),
    .out(c_hi_out), .tc(c_hi_tc), .wrap_pulse(c_hi_wp), .ovf(c_hi_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, advanced by tick() from the inputs present before each edge.
  int m_out = 0;
  bit m_ovf = 1'b0;
  bit m_wp  = 1'b0;
  bit exp_tc, seen_tc;

  task automatic tick();
    int raw;
    bit lim;
    #1;
    seen_tc = tc;
    exp_tc  = reset && !load && en && (up_dn ? (m_out == MAXV) : (m_out == 0));
    if (!reset) begin
      m_out = 0; m_wp = 0; m_ovf = 0;
    end else if (load) begin
      m_out = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_wp  = 0;
      m_ovf = m_ovf && !clr_ovf;
    end else if (en) begin
      raw = up_dn ? m_out + 1 : m_out - 1;
      lim = (raw < 0) || (raw > MAXV);
      if (!lim)          m_out = raw;
      else if (!sat_mode) m_out = (raw + MAXV + 1) % (MAXV + 1);
      m_wp  = lim;
      m_ovf = lim || (m_ovf && !clr_ovf);
    end else begin
      m_wp  = 0;
      m_ovf = m_ovf && !clr_ovf;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit r, input bit l, input int lv, input bit e,
                        input bit ud, input bit s, input bit c);
    reset = r; load = l; load_val = W'(lv); en = e; up_dn = ud; sat_mode = s; clr_ovf = c;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 1, 1, 0, 0);
    tick(); tick();
    n_checks++;
    if ({out, wrap_pulse, ovf} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got out=%0d wp=%b ovf=%b want out=0 wp=0 ovf=0", out, wrap_pulse, ovf);
    end
    set_in(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({seen_tc, out, wrap_pulse, ovf} !== {(i == 9), W'((i + 1) % 10), (i == 9), (i >= 9)}) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got tc=%b out=%0d wp=%b ovf=%b want tc=%b out=%0d wp=%b ovf=%b",
                 i, seen_tc, out, wrap_pulse, ovf, (i == 9), (i + 1) % 10, (i == 9), (i >= 9));
      end
    end
  endtask

  task automatic test_down_sat();
    int exp_seq [4] = '{1, 0, 0, 0};
    set_in(1, 1, 2, 0, 0, 1, 0);
    tick();
    n_checks++;
    if (out !== 4'd2) begin
      n_fail++;
      $display("FAIL down_load: got out=%0d want 2", out);
    end
    set_in(1, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({out, wrap_pulse} !== {W'(exp_seq[i]), (i >= 2)}) begin
        n_fail++;
        $display("FAIL down_sat[%0d]: got out=%0d wp=%b want out=%0d wp=%b",
                 i, out, wrap_pulse, exp_seq[i], (i >= 2));
      end
    end
  endtask

  task automatic test_load_clamp();
    set_in(1, 1, 13, 1, 1, 0, 0);
    tick();
    n_checks++;
    if ({seen_tc, out, wrap_pulse, ovf} !== {1'b0, 4'd9, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_clamp: got tc=%b out=%0d wp=%b ovf=%b want tc=0 out=9 wp=0 ovf=1",
               seen_tc, out, wrap_pulse, ovf);
    end
    set_in(1, 0, 0, 1, 1, 0, 0);
    tick();
    n_checks++;
    if ({seen_tc, out, wrap_pulse} !== {1'b1, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_then_wrap: got tc=%b out=%0d wp=%b want tc=1 out=0 wp=1",
               seen_tc, out, wrap_pulse);
    end
  endtask

  task automatic test_reset_mid();
    set_in(1, 1, 0, 0, 1, 0, 0);
    tick();
    set_in(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (out !== 4'd7) begin
      n_fail++;
      $display("FAIL mid_count: got out=%0d want 7", out);
    end
    set_in(0, 1, 3, 1, 1, 0, 0);
    tick();
    n_checks++;
    if ({seen_tc, out, wrap_pulse, ovf} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: got tc=%b out=%0d wp=%b ovf=%b want tc=0 out=0 wp=0 ovf=0",
               seen_tc, out, wrap_pulse, ovf);
    end
  endtask

  task automatic test_ovf_race();
    set_in(1, 1, 9, 0, 1, 0, 0);
    tick();
    set_in(1, 0, 0, 1, 1, 0, 1);
    tick();
    n_checks++;
    if ({out, ovf} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_race_set: got out=%0d ovf=%b want out=0 ovf=1", out, ovf);
    end
    set_in(1, 0, 0, 0, 1, 0, 1);
    tick();
    n_checks++;
    if ({out, ovf} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_clear: got out=%0d ovf=%b want out=0 ovf=0", out, ovf);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 31) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15),
             $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0);
      tick();
      n_checks++;
      if ({seen_tc, out, wrap_pulse, ovf} !== {exp_tc, W'(m_out), m_wp, m_ovf}) begin
        n_fail++;
        $display("FAIL random[%0d]: got tc=%b out=%0d wp=%b ovf=%b want tc=%b out=%0d wp=%b ovf=%b",
                 i, seen_tc, out, wrap_pulse, ovf, exp_tc, m_out, m_wp, m_ovf);
      end
    end
  endtask

  task automatic test_cascade();
    int hi_pulses = 0;
    int got;
    c_rst = 0; c_en = 1;
    @(posedge clk); #1;
    c_rst = 1;
    got = int'(c_hi_out) * 10 + int'(c_lo_out);
    n_checks++;
    if (got != 0) begin
      n_fail++;
      $display("FAIL cascade_start: got %0d want 0", got);
    end
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (c_hi_wp) hi_pulses++;
      got = int'(c_hi_out) * 10 + int'(c_lo_out);
      n_checks++;
      if (got != i % 100) begin
        n_fail++;
        $display("FAIL cascade[%0d]: got %0d want %0d", i, got, i % 100);
      end
    end
    n_checks++;
    if (hi_pulses != 1) begin
      n_fail++;
      $display("FAIL cascade_hi_wrap: got %0d pulses want 1", hi_pulses);
    end
  endtask

  initial begin
    c_rst = 0; c_en = 0; c_zero = 0; c_zero_val = '0;
    set_in(0, 0, 0, 0, 1, 0, 0);
    test_reset();
    test_down_sat();
    test_load_clamp();
    test_reset_mid();
    test_ovf_race();
    test_random();
    test_cascade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit counter.
- Configurable width and modulus, direction select, count enable and synchronous parallel load.
- Wrap or saturate mode, selected at run time.
- Provides a combinational terminal-count carry for cascading, plus registered wrap/overflow status, so stages can be chained into wider or BCD-style counters.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- MAX_VAL, 2**WIDTH-1, terminal value; the count range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1).
- INIT_VAL, 0, value loaded by reset (INIT_VAL <= MAX_VAL).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 at a rising clk edge resets the block).
- en  in  1  count enable; counts by one per cycle while high.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value taken on load.
- sat_mode  in  1  0 = wrap at the range limits, 1 = saturate at the range limits.
- clr_ovf  in  1  clears the sticky ovf flag.
- out  out  WIDTH  current count (registered).
- tc  out  1  terminal-count carry (combinational).
- wrap_pulse  out  1  one-cycle registered pulse after a limit event.
- ovf  out  1  sticky flag: a limit event has occurred.

Behaviour:
- Reset values: out=INIT_VAL, wrap_pulse=0, ovf=0. Reset overrides every other input. Reset asserted mid-count takes effect at the next edge, with no partial update.
- Priority at each edge: reset > load > en > hold.
- Load: out <= load_val. If load_val > MAX_VAL, out <= MAX_VAL (clamp).
  - A load never sets wrap_pulse or ovf.
  - A load in the same cycle as en ignores the count.
- Count, en=1, up_dn=1:
  - out < MAX_VAL: out <= out+1.
  - out == MAX_VAL: this is a limit event. Wrap mode gives out <= 0; saturate mode holds MAX_VAL.
- Count, en=1, up_dn=0:
  - out > 0: out <= out-1.
  - out == 0: this is a limit event. Wrap mode gives out <= MAX_VAL; saturate mode holds 0.
- en=0 and load=0: out holds. up_dn and sat_mode have no effect.
- tc (combinational) = en & ((up_dn & out==MAX_VAL) | (~up_dn & out==0)).
  - High in the cycle before the limit edge, so a cascaded stage uses tc as its en.
  - tc is independent of sat_mode and is forced 0 while reset=0 or load=1.
- wrap_pulse <= 1 for exactly the one cycle after an edge on which a limit event occurred, in either mode; otherwise 0.
- ovf:
  - Set on any limit event.
  - Cleared by clr_ovf=1 at an edge.
  - If a limit event and clr_ovf occur on the same edge, set wins (ovf=1).
- Arithmetic is done in WIDTH+1 bits internally. out never leaves the range 0..MAX_VAL.
- The direction may change on any cycle; the next edge uses the new up_dn.
- sat_mode is sampled per edge; changing it mid-count affects only the next limit event.
- Latency: 1 cycle from en/load to out; 0 cycles from out/en/up_dn to tc.

Decomposition:
- Shared package counter_pkg holds:
  - DIR_UP=1 and DIR_DOWN=0.
  - MODE_WRAP=0 and MODE_SAT=1.
  - A helper function for clamping a load value to MAX_VAL.
- Single module, no sub-module. The terminal-compare logic is small enough to stay inline.
- Cascaded wide counters are built at the next level up by chaining tc to en. This block does not instantiate itself.

Test Plan (WIDTH=4, MAX_VAL=9, INIT_VAL=0 unless stated):
- Reset: hold reset=0 for 2 edges with en=1 -> out=0, wrap_pulse=0, ovf=0. Release reset, en=1, up_dn=1, sat_mode=0 for 12 edges:
  - out steps 1..9, 0, 1, 2.
  - tc=1 while out=9.
  - wrap_pulse=1 for the one cycle after out goes 9->0.
  - ovf=1 afterwards.
- Down/saturate: load load_val=2, then en=1, up_dn=0, sat_mode=1 for 4 edges:
  - out = 2, 1, 0, 0, 0.
  - wrap_pulse high for each cycle following an edge taken at 0.
- Load priority and clamp:
  - load=1 with load_val=13 and en=1 -> out=9, no wrap_pulse, ovf unchanged.
  - Next edge, up wrap mode -> out=0.
- Reset mid-operation: count to 7, then drive reset=0 for one edge with load=1, load_val=3 -> out=0, ovf=0, wrap_pulse=0.
- ovf set/clear race: at out=9 with en=1, up_dn=1, clr_ovf=1 on the same edge -> ovf=1. clr_ovf=1 on the next edge with no event -> ovf=0.
- Cascade: two instances with MAX_VAL=9; the low stage's tc drives the high stage's en; run 100 edges from 00 up -> {hi,lo} reads 00..99 in sequence, then 00; the high stage's wrap_pulse fires once.
